o_buffer_drain: RTL

- Downstream consumer of the output buffer.
- Sequences read addresses over a block of output rows and captures the returned packed ACT_WIDTH-per-lane row data (ARRAY_M lanes).
- Delivers each row as one beat on a valid/ready stream toward the next-layer activation buffer / DMA.
- Absorbs buffer read latency and downstream back-pressure with a credit-controlled output FIFO.

---
 rtl/o_buffer_drain.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/o_buffer_drain.sv
// o_buffer_drain: walks a block of output-buffer rows and streams each row as one valid/ready beat.
// Optional: define O_BUFFER_DRAIN_RELU_EN to clamp negative lanes to zero as rows enter the FIFO.
module o_buffer_drain #(
    parameter int RAM_SIZE     = 256,
    parameter int ADDR_WIDTH   = $clog2(RAM_SIZE),
    parameter int ARRAY_M      = 8,
    parameter int ACT_WIDTH    = 8,
    parameter int READ_LATENCY = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [ADDR_WIDTH-1:0]          base_addr,
    input  logic [ADDR_WIDTH:0]            num_rows,
    output logic                           busy,
    output logic                           done,
    output logic [ADDR_WIDTH-1:0]          read_addr,
    input  logic [ACT_WIDTH*ARRAY_M-1:0]   rd_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [ACT_WIDTH*ARRAY_M-1:0]   m_data,
    output logic                           m_last
);
    localparam int DATA_W = ACT_WIDTH * ARRAY_M;
    localparam int CNT_W  = ADDR_WIDTH + 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W  = FCNT_W + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CNT_W-1:0]      rows_q;
    logic [CNT_W-1:0]      issue_cnt;
    logic [CNT_W-1:0]      out_cnt;
    logic [CNT_W-1:0]      issue_cnt_nxt;
    logic [CNT_W-1:0]      out_cnt_nxt;
    logic [ADDR_WIDTH-1:0] issue_addr;

    logic                  issue;
    logic                  credit_ok;
    logic                  fifo_wr;
    logic                  fifo_rd;
    logic [FCNT_W-1:0]     outstanding;
    logic [FCNT_W-1:0]     fifo_count;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [DATA_W-1:0]     wr_data;
    logic [DATA_W-1:0]     fifo_mem [FIFO_DEPTH];

    // A read may issue only if its row is guaranteed a FIFO slot when it returns.
    assign credit_ok     = (SUM_W'(outstanding) + SUM_W'(fifo_count)) < SUM_W'(FIFO_DEPTH);
    assign issue         = (state == ISSUE) && credit_ok;
    assign issue_addr    = base_q + issue_cnt[ADDR_WIDTH-1:0];
    assign read_addr     = issue ? issue_addr : addr_q;
    assign issue_cnt_nxt = issue_cnt + CNT_W'(1);
    assign out_cnt_nxt   = out_cnt + CNT_W'(1);

    generate
        if (READ_LATENCY == 0) begin : g_lat0
            assign fifo_wr     = issue;
            assign outstanding = '0;
        end else begin : g_latn
            logic [READ_LATENCY-1:0] vld_pipe;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) vld_pipe <= '0;
                else        vld_pipe <= (vld_pipe << 1) | READ_LATENCY'(issue);
            end

            assign fifo_wr     = vld_pipe[READ_LATENCY-1];
            assign outstanding = FCNT_W'($countones(vld_pipe));
        end
    endgenerate

    always_comb begin
        wr_data = rd_data;
`ifdef O_BUFFER_DRAIN_RELU_EN
        for (int m = 0; m < ARRAY_M; m++) begin
            if (rd_data[ACT_WIDTH*m + ACT_WIDTH-1]) wr_data[ACT_WIDTH*m +: ACT_WIDTH] = '0;
        end
`endif
    end

    // NOTE: FIFO storage is deliberately left unreset; m_data is masked to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (fifo_wr) fifo_mem[wr_ptr] <= wr_data;
    end

    assign m_valid = (fifo_count != '0);
    assign fifo_rd = m_valid && m_ready;
    assign m_data  = m_valid ? fifo_mem[rd_ptr] : '0;
    assign m_last  = m_valid && (out_cnt == rows_q - CNT_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH-1)) ? '0 : wr_ptr + 1'b1;
            if (fifo_rd) rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH-1)) ? '0 : rd_ptr + 1'b1;
            case ({fifo_wr, fifo_rd})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            base_q    <= '0;
            rows_q    <= '0;
            addr_q    <= '0;
            issue_cnt <= '0;
            out_cnt   <= '0;
        end else begin
            if (issue) begin
                addr_q    <= issue_addr;
                issue_cnt <= issue_cnt_nxt;
            end
            if (fifo_rd) out_cnt <= out_cnt_nxt;

            case (state)
                IDLE: begin
                    if (start) begin
                        base_q    <= base_addr;
                        rows_q    <= num_rows;
                        issue_cnt <= '0;
                        out_cnt   <= '0;
                        state     <= (num_rows == '0) ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue && issue_cnt_nxt == rows_q) state <= FLUSH;
                end
                FLUSH: begin
                    if (fifo_rd && out_cnt_nxt == rows_q) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == ISSUE) || (state == FLUSH);
    assign done = (state == DONE);

    a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        (fifo_wr && !fifo_rd) |-> (fifo_count < FCNT_W'(FIFO_DEPTH)));

endmodule
